pipe_ctrl: RTL and testbench
============================

# pipe_ctrl

Parametrised pipeline controller for the `mycpu_core` pipeline (IF, ID, EX, MEM, WB). It generalises the existing stall-only control to N stages. It adds a multi-cycle-operation hold timer, exception flush and redirect, and performance counters. It sits beside the stage modules and drives the shared `stall` bus, per-stage flush lines and the exception redirect into IF.

## Interface
Parameters:
- `STAGES`, 5, number of pipeline stages; stage k (1-based) is IF=1, ID=2, EX=3, MEM=4, WB=5.
- `MD_STAGE`, 3, stage that issues multi-cycle operations (EX).
- `MD_LAT`, 32, maximum hold cycles for one multi-cycle operation.
- `EXC_VEC`, 32'hBFC00380, exception redirect address.
- `PERF_W`, 32, performance counter width.

Ports:
- `clk` in 1: clock; the block has one clock.
- `rst` in 1: synchronous, active-high reset.
- `stallreq` in STAGES: bit k-1 set means stage k requests a stall this cycle.
- `md_start` in 1: one-cycle pulse when the `MD_STAGE` stage starts a multi-cycle operation.
- `md_done` in 1: the multi-cycle result is ready this cycle.
- `exc_req` in 1: exception committed this cycle.
- `exc_epc` in 32: PC of the excepting instruction, valid with `exc_req`.
- `stall` out STAGES+1: bit 0 holds the PC; bit k holds the stage-k pipeline register (matches `StallBus`).
- `flush` out STAGES: bit k-1 clears the stage-k register to a bubble.
- `new_pc_e` out 1: redirect IF to `new_pc` this cycle.
- `new_pc` out 32: redirect target.
- `epc` out 32: latched `exc_epc`.
- `md_timeout` out 1: sticky; set when an operation hits `MD_LAT` without `md_done`.
- `cycle_cnt`, `stall_cnt`, `exc_cnt` out PERF_W each: performance counters.

## Operation
- States: RUN, MDWAIT, EXC. Reset enters RUN.
- Effective request vector R = `stallreq` OR (bit `MD_STAGE`-1 when `md_start` is high in RUN, or when the state is MDWAIT).
- Stall rule: let s be the highest stage with R set. Then `stall[j]`=1 for all j<=s and 0 above s; if R=0, `stall`=0. Stage s+1 receives a bubble through the existing stage-register logic, which sees `stall[s]`=1 and `stall[s+1]`=0.
- RUN -> MDWAIT on `md_start`: hold counter loads 1.
- MDWAIT:
  - the counter increments each cycle;
  - on `md_done`, return to RUN; that cycle still stalls, and the stall releases the next cycle;
  - if the counter equals `MD_LAT` with no `md_done`, set `md_timeout` and return to RUN.
- `md_start` in MDWAIT is ignored.
- Exception, in any state:
  - in the `exc_req` cycle, `flush` is all ones, `stall` is forced to 0 and `epc` is latched;
  - the state then goes to EXC, and any MDWAIT operation is aborted with its counter cleared.
- EXC lasts exactly one cycle:
  - `new_pc_e`=1, `new_pc`=`EXC_VEC`;
  - `flush[0]`=1 drops the fetch issued in the `exc_req` cycle, and all other flush bits are 0;
  - `stall` follows the normal rule;
  - the state returns to RUN;
  - `exc_req` during EXC is ignored and `exc_cnt` is not incremented.
- Priority: `rst` > `exc_req` > `md_done`/timeout > `md_start`.
- Counters, all wrapping modulo 2^PERF_W:
  - `cycle_cnt` increments every non-reset cycle;
  - `stall_cnt` increments when `stall[0]`=1;
  - `exc_cnt` increments on each accepted `exc_req`.

## Timing
- `stall` and `flush` are combinational from inputs and the current state, valid in the same cycle as the request.
- Redirect latency: `new_pc_e` is asserted exactly 1 cycle after `exc_req`.
- Multi-cycle hold:
  - `stall` is high from the `md_start` cycle through the `md_done` cycle inclusive;
  - without `md_done`, the hold lasts `MD_LAT`+1 cycles counting the start cycle.
- `md_done` in the same cycle as `md_start` is not honoured; the hold starts regardless.
- Reset values: `stall`=0, `flush`=0, `new_pc_e`=0, `new_pc`=0, `epc`=0, `md_timeout`=0, all counters 0, state RUN.
- Reset mid-MDWAIT or mid-EXC returns to RUN the next cycle with no redirect.

## Test plan
- ID request only: `stallreq`=5'b00010 -> `stall`=6'b000111 and `flush`=0, in the same cycle.
- EX and MEM request together: `stallreq`=5'b01100 -> `stall`=6'b011111.
- Multi-cycle early finish: `md_start` at cycle 10, `md_done` at cycle 15 -> `stall[3:0]`=4'b1111 for cycles 10-15, and 0 at cycle 16.
  - `stall_cnt` increases by 6; `md_timeout` stays 0.
- Multi-cycle timeout: `MD_LAT`=4, `md_start` with no `md_done` -> stall for 5 cycles, `md_timeout`=1, state back to RUN.
- Exception during MDWAIT: `exc_req` with `exc_epc`=32'h8000_0010 at cycle 3 of a wait.
  - At that cycle: `flush`=5'b11111, `stall`=0, `epc`=32'h8000_0010 from the next cycle.
  - Next cycle: `new_pc_e`=1, `new_pc`=32'hBFC00380, `flush`=5'b00001.
  - `exc_cnt`=1; an `exc_req` in that EXC cycle is ignored.
- Reset mid-operation: `rst` during MDWAIT -> all outputs and counters 0 next cycle; the following `md_done` has no effect.

Source files
------------

// File: rtl/pipe_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_ctrl -- pipeline controller for the mycpu_core pipeline.
//
// Produces the shared stall bus, per-stage flush lines and the exception
// redirect into IF. It also tracks multi-cycle operations issued from
// MD_STAGE with a bounded hold timer, and keeps simple performance counters.
//
// Ports
//   clk         : clock
//   rst         : synchronous, active-high reset
//   stallreq    : per-stage stall requests, bit k-1 = stage k
//   md_start    : one-cycle pulse, MD_STAGE starts a multi-cycle operation
//   md_done     : multi-cycle result ready this cycle
//   exc_req     : exception committed this cycle
//   exc_epc     : PC of the excepting instruction, valid with exc_req
//   stall       : bit 0 holds the PC, bit k holds the stage-k register
//   flush       : bit k-1 turns the stage-k register into a bubble
//   new_pc_e    : redirect IF to new_pc this cycle
//   new_pc      : redirect target (EXC_VEC while new_pc_e is high, else 0)
//   epc         : PC latched from the last accepted exception
//   md_timeout  : sticky, a multi-cycle operation ran MD_LAT cycles undone
//   cycle_cnt   : non-reset cycles
//   stall_cnt   : cycles with stall[0] high
//   exc_cnt     : accepted exceptions
// -----------------------------------------------------------------------------
module pipe_ctrl #(
  parameter int          STAGES   = 5,
  parameter int          MD_STAGE = 3,
  parameter int          MD_LAT   = 32,
  parameter logic [31:0] EXC_VEC  = 32'hBFC00380,
  parameter int          PERF_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [STAGES-1:0] stallreq,
  input  logic              md_start,
  input  logic              md_done,
  input  logic              exc_req,
  input  logic [31:0]       exc_epc,
  output logic [STAGES:0]   stall,
  output logic [STAGES-1:0] flush,
  output logic              new_pc_e,
  output logic [31:0]       new_pc,
  output logic [31:0]       epc,
  output logic              md_timeout,
  output logic [PERF_W-1:0] cycle_cnt,
  output logic [PERF_W-1:0] stall_cnt,
  output logic [PERF_W-1:0] exc_cnt
);

  // Hold counter runs 1..MD_LAT while waiting on a multi-cycle operation.
  localparam int              CNT_W    = $clog2(MD_LAT + 1);
  localparam logic [CNT_W-1:0] MD_LAT_C = CNT_W'(MD_LAT);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    MDWAIT = 2'd1,
    EXC    = 2'd2
  } state_e;

  state_e            state_q,      state_d;
  logic [CNT_W-1:0]  md_cnt_q,     md_cnt_d;
  logic              md_timeout_q, md_timeout_d;
  logic              new_pc_e_q,   new_pc_e_d;
  logic [31:0]       new_pc_q,     new_pc_d;
  logic [31:0]       epc_q,        epc_d;
  logic [PERF_W-1:0] cycle_cnt_q,  cycle_cnt_d;
  logic [PERF_W-1:0] stall_cnt_q,  stall_cnt_d;
  logic [PERF_W-1:0] exc_cnt_q,    exc_cnt_d;

  logic              exc_acc;   // exception accepted this cycle
  logic              md_hold;   // MD_STAGE is held by a multi-cycle operation
  logic [STAGES-1:0] req;       // effective stall request vector

  // ---------------------------------------------------------------------------
  // Effective request vector. A multi-cycle operation stalls its own stage
  // from the start pulse onward, so the start cycle already holds the
  // pipeline. An exception raised while the redirect cycle is in progress is
  // dropped: the fetch it refers to is already being flushed.
  // ---------------------------------------------------------------------------
  // NOTE: every signal written in an always_comb gets a default on entry, so
  // no path through the block leaves it unassigned and infers a latch.
  always_comb begin
    exc_acc            = exc_req && (state_q != EXC);
    md_hold            = ((state_q == RUN) && md_start) || (state_q == MDWAIT);
    req                = stallreq;
    req[MD_STAGE-1]    = stallreq[MD_STAGE-1] | md_hold;
  end

  // ---------------------------------------------------------------------------
  // Stall and flush, combinational in the request cycle.
  // The highest requesting stage s freezes itself and everything upstream
  // (stall[0..s]); stage s+1 then takes a bubble in the stage-register logic.
  // An accepted exception overrides everything: the whole pipe is flushed and
  // nothing is held, so the redirect cycle starts from a clean pipeline. In
  // the redirect cycle only the IF register is flushed, dropping the fetch
  // that was issued alongside the exception.
  // ---------------------------------------------------------------------------
  always_comb begin
    stall = '0;
    flush = '0;
    if (!rst) begin
      if (exc_acc) begin
        flush = '1;
      end else begin
        stall[0] = |req;
        for (int k = 1; k <= STAGES; k++) begin
          stall[k] = |(req >> (k - 1));
        end
        flush[0] = (state_q == EXC);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and next-output logic.
  // Priority below reset: exception, then md_done / timeout, then md_start.
  // md_done is only looked at in MDWAIT, so a done pulse coincident with the
  // start pulse is ignored and the hold always lasts at least two cycles.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    md_cnt_d     = md_cnt_q;
    md_timeout_d = md_timeout_q;

    unique case (state_q)
      RUN: begin
        if (md_start) begin
          state_d  = MDWAIT;
          md_cnt_d = CNT_W'(1);
        end
      end
      MDWAIT: begin
        if (md_done) begin
          state_d  = RUN;
          md_cnt_d = '0;
        end else if (md_cnt_q == MD_LAT_C) begin
          // Give up on the operation; the stall releases next cycle and the
          // sticky flag lets software find out what happened.
          state_d      = RUN;
          md_cnt_d     = '0;
          md_timeout_d = 1'b1;
        end else begin
          md_cnt_d = md_cnt_q + CNT_W'(1);
        end
      end
      EXC: begin
        state_d = RUN;
      end
      default: begin
        state_d  = RUN;
        md_cnt_d = '0;
      end
    endcase

    // Exception aborts any pending multi-cycle wait.
    if (exc_acc) begin
      state_d  = EXC;
      md_cnt_d = '0;
    end

    // Redirect is registered so it appears exactly in the EXC cycle.
    new_pc_e_d = exc_acc;
    new_pc_d   = exc_acc ? EXC_VEC : '0;
    epc_d      = exc_acc ? exc_epc : epc_q;

    // Free-running counters; they wrap naturally at 2^PERF_W.
    cycle_cnt_d = cycle_cnt_q + PERF_W'(1);
    stall_cnt_d = stall_cnt_q + PERF_W'(stall[0]);
    exc_cnt_d   = exc_cnt_q + PERF_W'(exc_acc);
  end

  // ---------------------------------------------------------------------------
  // State and output registers.
  // ---------------------------------------------------------------------------
  // NOTE: non-blocking assignments here so every flop samples the values that
  // existed before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= RUN;
      md_cnt_q     <= '0;
      md_timeout_q <= 1'b0;
      new_pc_e_q   <= 1'b0;
      new_pc_q     <= '0;
      epc_q        <= '0;
      cycle_cnt_q  <= '0;
      stall_cnt_q  <= '0;
      exc_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      md_cnt_q     <= md_cnt_d;
      md_timeout_q <= md_timeout_d;
      new_pc_e_q   <= new_pc_e_d;
      new_pc_q     <= new_pc_d;
      epc_q        <= epc_d;
      cycle_cnt_q  <= cycle_cnt_d;
      stall_cnt_q  <= stall_cnt_d;
      exc_cnt_q    <= exc_cnt_d;
    end
  end

  assign new_pc_e   = new_pc_e_q;
  assign new_pc     = new_pc_q;
  assign epc        = epc_q;
  assign md_timeout = md_timeout_q;
  assign cycle_cnt  = cycle_cnt_q;
  assign stall_cnt  = stall_cnt_q;
  assign exc_cnt    = exc_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_ctrl -- self-checking bench for pipe_ctrl.
//
// Two instances share every input: u_dut with the default MD_LAT (32) and
// u_dut4 with MD_LAT=4 for the hold-timeout case. Each cycle's expected
// stall/flush is pushed to a scoreboard when the inputs are driven and popped
// and compared on the falling edge. A small model tracks the three perf
// counters. Registered outputs are checked 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_pipe_ctrl;

  localparam logic [31:0] EXC_VEC = 32'hBFC00380;
  localparam logic [5:0]  S_MD    = 6'b001111;  // hold of EX and upstream

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  stallreq;
  logic        md_start, md_done, exc_req;
  logic [31:0] exc_epc;

  logic [5:0]  stall;
  logic [4:0]  flush;
  logic        new_pc_e, md_timeout;
  logic [31:0] new_pc, epc, cycle_cnt, stall_cnt, exc_cnt;

  logic [5:0]  stall4;
  logic [4:0]  flush4;
  logic        new_pc_e4, md_timeout4;
  logic [31:0] new_pc4, epc4, cycle_cnt4, stall_cnt4, exc_cnt4;

  always #5 clk = ~clk;

  pipe_ctrl u_dut (
    .clk(clk), .rst(rst), .stallreq(stallreq), .md_start(md_start),
    .md_done(md_done), .exc_req(exc_req), .exc_epc(exc_epc),
    .stall(stall), .flush(flush), .new_pc_e(new_pc_e), .new_pc(new_pc),
    .epc(epc), .md_timeout(md_timeout), .cycle_cnt(cycle_cnt),
    .stall_cnt(stall_cnt), .exc_cnt(exc_cnt)
  );

  pipe_ctrl #(.MD_LAT(4)) u_dut4 (
    .clk(clk), .rst(rst), .stallreq(stallreq), .md_start(md_start),
    .md_done(md_done), .exc_req(exc_req), .exc_epc(exc_epc),
    .stall(stall4), .flush(flush4), .new_pc_e(new_pc_e4), .new_pc(new_pc4),
    .epc(epc4), .md_timeout(md_timeout4), .cycle_cnt(cycle_cnt4),
    .stall_cnt(stall_cnt4), .exc_cnt(exc_cnt4)
  );

  typedef struct {
    logic [4:0]  sr;
    logic        ms;
    logic        md;
    logic        er;
    logic [31:0] ep;
    logic [5:0]  e_stall;
    logic [4:0]  e_flush;
    logic        c4;        // also compare the MD_LAT=4 instance
    logic [5:0]  e_stall4;
  } vec_t;

  vec_t sb[$];
  vec_t tbl[10];

  int n_vec = 0;
  int n_err = 0;
  int m_cycle, m_stall, m_exc;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [4:0] sr, input logic ms, input logic md,
                              input logic er, input logic [31:0] ep,
                              input logic [5:0] es, input logic [4:0] ef);
    vec_t v;
    v.sr = sr; v.ms = ms; v.md = md; v.er = er; v.ep = ep;
    v.e_stall = es; v.e_flush = ef; v.c4 = 1'b0; v.e_stall4 = '0;
    return v;
  endfunction

  function automatic vec_t mk4(input logic ms, input logic [5:0] es, input logic [5:0] es4);
    vec_t v;
    v = mk(5'b0, ms, 1'b0, 1'b0, 32'h0, es, 5'b0);
    v.c4 = 1'b1;
    v.e_stall4 = es4;
    return v;
  endfunction

  // One clock cycle: drive, compare on the falling edge, advance the model.
  task automatic step(input string name, input vec_t v);
    vec_t e;
    stallreq = v.sr; md_start = v.ms; md_done = v.md;
    exc_req  = v.er; exc_epc  = v.ep;
    sb.push_back(v);
    @(negedge clk);
    e = sb.pop_front();
    check({name, " stall"}, 64'(stall), 64'(e.e_stall));
    check({name, " flush"}, 64'(flush), 64'(e.e_flush));
    if (e.c4) check({name, " stall(MD_LAT=4)"}, 64'(stall4), 64'(e.e_stall4));
    check({name, " cycle_cnt"}, 64'(cycle_cnt), 64'(m_cycle));
    check({name, " stall_cnt"}, 64'(stall_cnt), 64'(m_stall));
    check({name, " exc_cnt"},   64'(exc_cnt),   64'(m_exc));
    m_cycle++;
    if (e.e_stall[0]) m_stall++;
    if (e.e_flush == 5'b11111) m_exc++;
    @(posedge clk);
    #1;
    stallreq = '0; md_start = 1'b0; md_done = 1'b0; exc_req = 1'b0; exc_epc = '0;
  endtask

  task automatic do_reset(input int cycles);
    stallreq = '0; md_start = 1'b0; md_done = 1'b0; exc_req = 1'b0; exc_epc = '0;
    rst = 1'b1;
    repeat (cycles) @(posedge clk);
    #1;
    rst = 1'b0;
    m_cycle = 0; m_stall = 0; m_exc = 0;
    #1;
  endtask

  task automatic check_reset_vals(input string name);
    check({name, " stall"},      64'(stall),      64'(0));
    check({name, " flush"},      64'(flush),      64'(0));
    check({name, " new_pc_e"},   64'(new_pc_e),   64'(0));
    check({name, " new_pc"},     64'(new_pc),     64'(0));
    check({name, " epc"},        64'(epc),        64'(0));
    check({name, " md_timeout"}, 64'(md_timeout), 64'(0));
    check({name, " cycle_cnt"},  64'(cycle_cnt),  64'(0));
    check({name, " stall_cnt"},  64'(stall_cnt),  64'(0));
    check({name, " exc_cnt"},    64'(exc_cnt),    64'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit of 100000 reached before the summary");
    $fatal(1, "watchdog");
  end

  initial begin
    // Stall-rule vectors, all issued in RUN with no multi-cycle or exception.
    tbl[0] = mk(5'b00000, 0, 0, 0, 32'h0, 6'b000000, 5'b0);
    tbl[1] = mk(5'b00001, 0, 0, 0, 32'h0, 6'b000011, 5'b0);
    tbl[2] = mk(5'b00010, 0, 0, 0, 32'h0, 6'b000111, 5'b0);
    tbl[3] = mk(5'b00100, 0, 0, 0, 32'h0, 6'b001111, 5'b0);
    tbl[4] = mk(5'b01100, 0, 0, 0, 32'h0, 6'b011111, 5'b0);
    tbl[5] = mk(5'b10000, 0, 0, 0, 32'h0, 6'b111111, 5'b0);
    tbl[6] = mk(5'b10101, 0, 0, 0, 32'h0, 6'b111111, 5'b0);
    tbl[7] = mk(5'b01001, 0, 0, 0, 32'h0, 6'b011111, 5'b0);
    tbl[8] = mk(5'b00110, 0, 0, 0, 32'h0, 6'b001111, 5'b0);
    tbl[9] = mk(5'b00000, 0, 1, 0, 32'h0, 6'b000000, 5'b0);  // stray md_done

    rst = 1'b1;
    do_reset(2);
    check_reset_vals("reset");

    for (int i = 0; i < 10; i++) step($sformatf("tbl[%0d]", i), tbl[i]);

    // Multi-cycle early finish: hold from start through done, 6 cycles.
    step("md_early start", mk(5'b0, 1, 0, 0, 32'h0, S_MD, 5'b0));
    step("md_early w1",    mk(5'b0, 0, 0, 0, 32'h0, S_MD, 5'b0));
    step("md_early w2",    mk(5'b0, 1, 0, 0, 32'h0, S_MD, 5'b0));  // start ignored
    step("md_early w3",    mk(5'b0, 0, 0, 0, 32'h0, S_MD, 5'b0));
    step("md_early w4",    mk(5'b0, 0, 0, 0, 32'h0, S_MD, 5'b0));
    step("md_early done",  mk(5'b0, 0, 1, 0, 32'h0, S_MD, 5'b0));
    step("md_early free",  mk(5'b0, 0, 0, 0, 32'h0, 6'b0, 5'b0));
    check("md_early md_timeout", 64'(md_timeout), 64'(0));

    // Done in the start cycle is not honoured.
    do_reset(1);
    step("md_same start+done", mk(5'b0, 1, 1, 0, 32'h0, S_MD, 5'b0));
    step("md_same done",       mk(5'b0, 0, 1, 0, 32'h0, S_MD, 5'b0));
    step("md_same free",       mk(5'b0, 0, 0, 0, 32'h0, 6'b0, 5'b0));

    // Timeout on the MD_LAT=4 instance: 5 stall cycles, then sticky flag.
    do_reset(1);
    step("md_to start", mk4(1, S_MD, S_MD));
    step("md_to w1",    mk4(0, S_MD, S_MD));
    step("md_to w2",    mk4(0, S_MD, S_MD));
    step("md_to w3",    mk4(0, S_MD, S_MD));
    check("md_to md_timeout4 before limit", 64'(md_timeout4), 64'(0));
    step("md_to w4",    mk4(0, S_MD, S_MD));
    check("md_to md_timeout4 at limit", 64'(md_timeout4), 64'(1));
    step("md_to after", mk4(0, S_MD, 6'b0));
    check("md_to md_timeout4 sticky", 64'(md_timeout4), 64'(1));
    check("md_to md_timeout (MD_LAT=32)", 64'(md_timeout), 64'(0));

    // Exception during a multi-cycle wait, then the redirect cycle.
    do_reset(1);
    step("exc start", mk(5'b0, 1, 0, 0, 32'h0, S_MD, 5'b0));
    step("exc w1",    mk(5'b0, 0, 0, 0, 32'h0, S_MD, 5'b0));
    step("exc w2",    mk(5'b0, 0, 0, 0, 32'h0, S_MD, 5'b0));
    step("exc req",   mk(5'b00010, 0, 0, 1, 32'h8000_0010, 6'b0, 5'b11111));
    check("exc new_pc_e", 64'(new_pc_e), 64'(1));
    check("exc new_pc",   64'(new_pc),   64'(EXC_VEC));
    check("exc epc",      64'(epc),      64'(32'h8000_0010));
    step("exc redirect",  mk(5'b00100, 0, 0, 1, 32'hDEAD_0000, S_MD, 5'b00001));
    check("exc post new_pc_e", 64'(new_pc_e), 64'(0));
    check("exc post new_pc",   64'(new_pc),   64'(0));
    check("exc post epc",      64'(epc),      64'(32'h8000_0010));
    step("exc run",   mk(5'b0, 0, 0, 0, 32'h0, 6'b0, 5'b0));

    // Exception beats md_start in the same cycle.
    step("exc+start req",  mk(5'b0, 1, 0, 1, 32'h8000_0020, 6'b0, 5'b11111));
    check("exc+start epc",      64'(epc),      64'(32'h8000_0020));
    check("exc+start new_pc_e", 64'(new_pc_e), 64'(1));
    step("exc+start redirect", mk(5'b0, 0, 0, 0, 32'h0, 6'b0, 5'b00001));
    step("exc+start run",      mk(5'b0, 0, 0, 0, 32'h0, 6'b0, 5'b0));

    // Reset during MDWAIT: everything clears, a late md_done is harmless.
    step("rst_md start", mk(5'b0, 1, 0, 0, 32'h0, S_MD, 5'b0));
    step("rst_md w1",    mk(5'b0, 0, 0, 0, 32'h0, S_MD, 5'b0));
    do_reset(1);
    check_reset_vals("rst_md");
    step("rst_md late done", mk(5'b0, 0, 1, 0, 32'h0, 6'b0, 5'b0));
    step("rst_md idle",      mk(5'b0, 0, 0, 0, 32'h0, 6'b0, 5'b0));

    // Reset during the redirect cycle: back to RUN, no redirect, no IF flush.
    step("rst_exc req", mk(5'b0, 0, 0, 1, 32'h1234_5678, 6'b0, 5'b11111));
    do_reset(1);
    check_reset_vals("rst_exc");
    step("rst_exc idle", mk(5'b0, 0, 0, 0, 32'h0, 6'b0, 5'b0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
